// File: rtl/riscv_clint_timer_if.sv
// Register-port bundle between the load/store unit (master) and the CLINT timer (slave).
// Signals:
//   req_valid/req_ready  request handshake; a request is accepted when both are high
//   req_write            1 = write, 0 = read
//   req_addr             byte offset of the register
//   req_wdata            write data
//   resp_valid/resp_ready response handshake; the response is consumed when both are high
//   resp_rdata           read data (0 for writes and errors)
//   resp_error           access to an unmapped offset
interface riscv_clint_timer_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [4:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/riscv_clint_timer.sv
// CLINT-style machine timer and software-interrupt source.
// Holds the 64-bit mtime counter, the 64-bit mtimecmp compare value and the MSIP bit,
// and exposes them over a single-outstanding valid/ready register port.
// Ports:
//   clk         clock
//   rst_n       asynchronous reset, asserted HIGH (legacy name kept for the codebase)
//   bus         register port (slave side of riscv_clint_timer_if)
//   timer_intr  registered mtime >= mtimecmp (unsigned 64-bit), feeds mip.MTIP
//   sw_intr     MSIP bit, feeds mip.MSIP
// Register map (byte offsets): 0x00 MSIP, 0x08 MTIMECMP_LO, 0x0C MTIMECMP_HI,
//   0x10 MTIME_LO, 0x14 MTIME_HI. Everything else answers with resp_error.
// PRESCALE: clk cycles per mtime tick, 1..65535 (0 is not a legal setting).
module riscv_clint_timer #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  riscv_clint_timer_if.slave    bus,
  output logic                  timer_intr,
  output logic                  sw_intr
);

  localparam logic [15:0] PRESCALE_LAST = 16'(PRESCALE - 1);

  logic [63:0] mtime_r;
  logic [63:0] mtimecmp_r;
  logic        msip_r;
  logic [15:0] pre_cnt_r;
  logic [31:0] hi_shadow_r;
  logic        resp_valid_r;
  logic [31:0] resp_rdata_r;
  logic        resp_error_r;
  logic        timer_intr_r;

  logic        accept_s;
  logic        wr_s;
  logic        tick_s;
  logic        sel_msip_s;
  logic        sel_cmp_lo_s;
  logic        sel_cmp_hi_s;
  logic        sel_time_lo_s;
  logic        sel_time_hi_s;
  logic [31:0] rd_mux_s;
  logic [31:0] rdata_s;
  logic        error_s;

  // A new request may enter whenever the response slot is empty or is being drained.
  assign bus.req_ready = !resp_valid_r || bus.resp_ready;
  assign accept_s      = bus.req_valid && bus.req_ready;
  assign wr_s          = accept_s && bus.req_write;
  assign tick_s        = (pre_cnt_r == PRESCALE_LAST);

  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_rdata = resp_rdata_r;
  assign bus.resp_error = resp_error_r;
  assign timer_intr     = timer_intr_r;
  assign sw_intr        = msip_r;

  // Address decode and read-data selection from pre-update register values.
  always_comb begin
    sel_msip_s    = 1'b0;
    sel_cmp_lo_s  = 1'b0;
    sel_cmp_hi_s  = 1'b0;
    sel_time_lo_s = 1'b0;
    sel_time_hi_s = 1'b0;
    rd_mux_s      = 32'h0000_0000;
    error_s       = 1'b0;
    case (bus.req_addr)
      5'h00: begin
        sel_msip_s = 1'b1;
        rd_mux_s   = {31'h0000_0000, msip_r};
      end
      5'h08: begin
        sel_cmp_lo_s = 1'b1;
        rd_mux_s     = mtimecmp_r[31:0];
      end
      5'h0C: begin
        sel_cmp_hi_s = 1'b1;
        rd_mux_s     = mtimecmp_r[63:32];
      end
      5'h10: begin
        sel_time_lo_s = 1'b1;
        rd_mux_s      = mtime_r[31:0];
      end
      5'h14: begin
        // HI returns the snapshot taken by the last LO read, so LO-then-HI is atomic.
        sel_time_hi_s = 1'b1;
        rd_mux_s      = hi_shadow_r;
      end
      default: begin
        error_s  = 1'b1;
        rd_mux_s = 32'h0000_0000;
      end
    endcase
    if (bus.req_write) begin
      rdata_s = 32'h0000_0000;
    end else begin
      rdata_s = rd_mux_s;
    end
  end

  // mtime counter with prescaler; a software write to either half wins over the tick
  // and restarts the prescale phase.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      mtime_r   <= 64'h0000_0000_0000_0000;
      pre_cnt_r <= 16'h0000;
    end else if (wr_s && sel_time_lo_s) begin
      mtime_r[31:0] <= bus.req_wdata;
      pre_cnt_r     <= 16'h0000;
    end else if (wr_s && sel_time_hi_s) begin
      mtime_r[63:32] <= bus.req_wdata;
      pre_cnt_r      <= 16'h0000;
    end else if (tick_s) begin
      mtime_r   <= mtime_r + 64'd1;
      pre_cnt_r <= 16'h0000;
    end else begin
      pre_cnt_r <= pre_cnt_r + 16'd1;
    end
  end

  // Software-writable state: mtimecmp halves, MSIP and the MTIME_HI read shadow.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      mtimecmp_r  <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip_r      <= 1'b0;
      hi_shadow_r <= 32'h0000_0000;
    end else begin
      if (wr_s && sel_cmp_lo_s) begin
        mtimecmp_r[31:0] <= bus.req_wdata;
      end else if (wr_s && sel_cmp_hi_s) begin
        mtimecmp_r[63:32] <= bus.req_wdata;
      end else begin
        mtimecmp_r <= mtimecmp_r;
      end
      if (wr_s && sel_msip_s) begin
        msip_r <= bus.req_wdata[0];
      end else begin
        msip_r <= msip_r;
      end
      if (accept_s && !bus.req_write && sel_time_lo_s) begin
        hi_shadow_r <= mtime_r[63:32];
      end else begin
        hi_shadow_r <= hi_shadow_r;
      end
    end
  end

  // Response slot: loaded on accept, held until the consumer takes it.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'h0000_0000;
      resp_error_r <= 1'b0;
    end else if (accept_s) begin
      resp_valid_r <= 1'b1;
      resp_rdata_r <= rdata_s;
      resp_error_r <= error_s;
    end else if (bus.resp_ready) begin
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'h0000_0000;
      resp_error_r <= 1'b0;
    end else begin
      resp_valid_r <= resp_valid_r;
      resp_rdata_r <= resp_rdata_r;
      resp_error_r <= resp_error_r;
    end
  end

  // Timer interrupt compares the current (pre-update) values, so it lags by one cycle.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      timer_intr_r <= 1'b0;
    end else begin
      timer_intr_r <= (mtime_r >= mtimecmp_r);
    end
  end

endmodule
